rvfi_dii_bridge: RTL

RVFI_DII_BRIDGE -- requirements
Module: rvfi_dii_bridge

---
 rtl/rvfi_dii_pkg.sv | 59 +++++
 rtl/rvfi_dii_bridge_if.sv | 61 ++++++
 rtl/rvfi_pkt_serializer.sv | 64 ++++++
 rtl/rvfi_dii_bridge.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rvfi_dii_pkg.sv
// Shared types and constants for the RVFI-DII bridge: FSM states, command
// encodings, packet layout and the trace meta-word builder.
package rvfi_dii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RET = 3'd2,
        ST_SEND     = 3'd3,
        ST_CORE_RST = 3'd4
    } state_e;

    localparam logic CMD_INSTR = 1'b0;
    localparam logic CMD_RESET = 1'b1;

    localparam int PKT_WORDS = 8;
    localparam int IDX_W     = $clog2(PKT_WORDS);

    localparam int META_HALT      = 31;
    localparam int META_TRAP      = 30;
    localparam int META_RD_LSB    = 25;
    localparam int META_RMASK_LSB = 21;
    localparam int META_WMASK_LSB = 17;
    localparam int META_PRIV_LSB  = 15;
    localparam int META_INT_VALID = 14;
    localparam int META_MEM_VALID = 13;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic        halt;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [1:0]  priv;
    } pkt_t;

    // Trapped retirements never report a register or memory side effect.
    function automatic logic [31:0] build_meta(pkt_t p);
        logic [31:0] m;
        m = '0;
        m[META_HALT]                = p.halt;
        m[META_TRAP]                = p.trap;
        m[META_RD_LSB    +: 5]      = p.rd_addr;
        m[META_RMASK_LSB +: 4]      = p.mem_rmask;
        m[META_WMASK_LSB +: 4]      = p.mem_wmask;
        m[META_PRIV_LSB  +: 2]      = p.priv;
        m[META_INT_VALID]           = !p.trap && (p.rd_addr != 5'd0);
        m[META_MEM_VALID]           = !p.trap && ((p.mem_rmask | p.mem_wmask) != 4'd0);
        return m;
    endfunction

endpackage

// File: rtl/rvfi_dii_bridge_if.sv
// Signal bundle between the DII host, the core under test and the bridge.
// slave = bridge side, master = host/core side.
interface rvfi_dii_bridge_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [31:0] cmd_instr;

    logic        core_instr_valid;
    logic        core_instr_ready;
    logic [31:0] core_instr;
    logic        core_rst;

    logic        ret_valid;
    logic [31:0] ret_pc_rdata;
    logic [31:0] ret_pc_wdata;
    logic [31:0] ret_insn;
    logic [31:0] ret_rd_wdata;
    logic [31:0] ret_mem_addr;
    logic [31:0] ret_mem_rdata;
    logic [31:0] ret_mem_wdata;
    logic        ret_trap;
    logic [4:0]  ret_rd_addr;
    logic [3:0]  ret_mem_rmask;
    logic [3:0]  ret_mem_wmask;
    logic [1:0]  ret_priv;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        err_sticky;

    modport slave (
        input  cmd_valid, cmd_type, cmd_instr,
        output cmd_ready,
        output core_instr_valid, core_instr, core_rst,
        input  core_instr_ready,
        input  ret_valid, ret_pc_rdata, ret_pc_wdata, ret_insn, ret_rd_wdata,
        input  ret_mem_addr, ret_mem_rdata, ret_mem_wdata, ret_trap,
        input  ret_rd_addr, ret_mem_rmask, ret_mem_wmask, ret_priv,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output err_sticky
    );

    modport master (
        output cmd_valid, cmd_type, cmd_instr,
        input  cmd_ready,
        input  core_instr_valid, core_instr, core_rst,
        output core_instr_ready,
        output ret_valid, ret_pc_rdata, ret_pc_wdata, ret_insn, ret_rd_wdata,
        output ret_mem_addr, ret_mem_rdata, ret_mem_wdata, ret_trap,
        output ret_rd_addr, ret_mem_rmask, ret_mem_wmask, ret_priv,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  err_sticky
    );

endinterface

// File: rtl/rvfi_pkt_serializer.sv
// Holds one trace packet and streams it as PKT_WORDS 32-bit words over a
// valid/ready channel; a new load restarts from word 0.
module rvfi_pkt_serializer
    import rvfi_dii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  pkt_t        pkt_in,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    pkt_t             pkt_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic [31:0]      word;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else if (load) begin
            pkt_q  <= pkt_in;
            idx_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q && rsp_ready) begin
            if (idx_q == LAST_IDX) begin
                idx_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        word = '0;
        case (idx_q)
            3'd0: word = pkt_q.pc_rdata;
            3'd1: word = pkt_q.pc_wdata;
            3'd2: word = pkt_q.insn;
            3'd3: word = pkt_q.rd_wdata;
            3'd4: word = pkt_q.mem_addr;
            3'd5: word = pkt_q.mem_rdata;
            3'd6: word = pkt_q.mem_wdata;
            3'd7: word = build_meta(pkt_q);
            default: word = '0;
        endcase
    end

    // Bus reads zero whenever no packet is being offered.
    assign rsp_valid = busy_q;
    assign rsp_data  = busy_q ? word : 32'd0;
    assign rsp_last  = busy_q && (idx_q == LAST_IDX);
    assign done      = busy_q && rsp_ready && (idx_q == LAST_IDX);

endmodule

// File: rtl/rvfi_dii_bridge.sv
// RVFI-DII bridge: injects host instructions into the core, captures the
// retirement record and returns it to the host as an 8-word trace packet.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | ready for a host command
// ISSUE       | instruction offered to core, waiting for core_instr_ready
// WAIT_RET    | waiting for retirement, timeout timer running
// SEND        | serializer streaming the packet to the host
// CORE_RST    | core reset pulse in progress
module rvfi_dii_bridge
    import rvfi_dii_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int RET_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    rvfi_dii_bridge_if.slave bus
);

    localparam logic [15:0] TMO_LOAD = 16'(RET_TIMEOUT - 1);
    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] tmr_q, tmr_d;
    logic        err_q, err_d;

    pkt_t        ret_pkt;
    pkt_t        pkt_new;
    logic        pkt_load;
    logic        pkt_done;

    always_comb begin
        ret_pkt           = '0;
        ret_pkt.pc_rdata  = bus.ret_pc_rdata;
        ret_pkt.pc_wdata  = bus.ret_pc_wdata;
        ret_pkt.insn      = bus.ret_insn;
        ret_pkt.rd_wdata  = (bus.ret_rd_addr == 5'd0) ? 32'd0 : bus.ret_rd_wdata;
        ret_pkt.mem_addr  = bus.ret_mem_addr;
        ret_pkt.mem_rdata = bus.ret_mem_rdata;
        ret_pkt.mem_wdata = bus.ret_mem_wdata;
        ret_pkt.trap      = bus.ret_trap;
        ret_pkt.rd_addr   = bus.ret_rd_addr;
        ret_pkt.mem_rmask = bus.ret_mem_rmask;
        ret_pkt.mem_wmask = bus.ret_mem_wmask;
        ret_pkt.priv      = bus.ret_priv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        pkt_load = 1'b0;
        pkt_new  = '0;

        if (bus.ret_valid && (state_q != ST_WAIT_RET)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_type == CMD_RESET) begin
                        state_d = ST_CORE_RST;
                        tmr_d   = RST_LOAD;
                    end else begin
                        state_d = ST_ISSUE;
                        instr_d = bus.cmd_instr;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.core_instr_ready) begin
                    state_d = ST_WAIT_RET;
                    tmr_d   = TMO_LOAD;
                end
            end
            ST_WAIT_RET: begin
                // A retirement on the terminal-count cycle still wins.
                if (bus.ret_valid) begin
                    pkt_load = 1'b1;
                    pkt_new  = ret_pkt;
                    state_d  = ST_SEND;
                end else if (tmr_q == 16'd0) begin
                    pkt_load     = 1'b1;
                    pkt_new.trap = 1'b1;
                    err_d        = 1'b1;
                    state_d      = ST_SEND;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_SEND: begin
                if (pkt_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CORE_RST: begin
                if (tmr_q == 16'd0) begin
                    pkt_load     = 1'b1;
                    pkt_new.halt = 1'b1;
                    state_d      = ST_SEND;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rvfi_pkt_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (pkt_load),
        .pkt_in    (pkt_new),
        .rsp_ready (bus.rsp_ready),
        .rsp_valid (bus.rsp_valid),
        .rsp_data  (bus.rsp_data),
        .rsp_last  (bus.rsp_last),
        .done      (pkt_done)
    );

    // The core is held in reset for as long as the bridge itself is.
    assign bus.cmd_ready        = !rst && (state_q == ST_IDLE);
    assign bus.core_instr_valid = !rst && (state_q == ST_ISSUE);
    assign bus.core_instr       = instr_q;
    assign bus.core_rst         = rst || (state_q == ST_CORE_RST);
    assign bus.err_sticky       = err_q;

endmodule
